// File: rtl/seg_display_pkg.sv
// Shared constants for the 7-segment display multiplexer.
// Glyph patterns are internal active-high, bit order {A,B,C,D,E,F,G}.
// Also holds the special digit codes and a width helper used for index/prescaler sizing.
package seg_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] CODE_DASH  = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hB;

   // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit signal.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Purpose: combinational digit-code to 7-segment glyph decoder (active-high, {A..G}).
// Ports: code = 4-bit digit code; hexMode = 1 shows A..F for codes 10..15,
//        0 shows dash for 10 and blank for 11..15; segments = active-high pattern.
module seg7_glyph
   import seg_display_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hexMode,
   output logic [6:0] segments
);

   always_comb begin
      segments = SEG_BLANK;
      case (code)
         4'h0: segments = SEG_0;
         4'h1: segments = SEG_1;
         4'h2: segments = SEG_2;
         4'h3: segments = SEG_3;
         4'h4: segments = SEG_4;
         4'h5: segments = SEG_5;
         4'h6: segments = SEG_6;
         4'h7: segments = SEG_7;
         4'h8: segments = SEG_8;
         4'h9: segments = SEG_9;
         4'hA: segments = hexMode ? SEG_A : SEG_DASH;
         4'hB: segments = hexMode ? SEG_B : SEG_BLANK;
         4'hC: segments = hexMode ? SEG_C : SEG_BLANK;
         4'hD: segments = hexMode ? SEG_D : SEG_BLANK;
         4'hE: segments = hexMode ? SEG_E : SEG_BLANK;
         4'hF: segments = hexMode ? SEG_F : SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_display_mux.sv
// Purpose: time-multiplexed DIGITS-digit 7-segment driver with shadow register,
//          leading-zero blanking, per-digit decimal point and selectable pin polarity.
// Ports: clock/reset (async, active-high); num/dp_in/load = value capture;
//        enable = anode gate; seg/dp/an = registered physical pins; digit_idx = active digit.
module seg_display_mux
   import seg_display_pkg::*;
#(
   parameter  int DIGITS         = 4,
   parameter  int CLK_DIV        = 50000,
   parameter  int HEX_MODE       = 0,
   parameter  int LZ_BLANK       = 1,
   parameter  int SEG_ACTIVE_LOW = 1,
   parameter  int AN_ACTIVE_LOW  = 1,
   localparam int IDX_W          = clog2_min1(DIGITS)
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   num,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  load,
   input  logic                  enable,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic [IDX_W-1:0]      digit_idx
);

   localparam int                PRE_W    = clog2_min1(CLK_DIV);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [PRE_W-1:0]  prescaler;
   logic              tick;
   logic [IDX_W-1:0]  scanIdx;
   logic [IDX_W-1:0]  nextIdx;
   logic [3:0]        shadowCode [DIGITS];
   logic [DIGITS-1:0] shadowDp;

   logic [DIGITS-1:0] lzMask;
   logic              upperZero;
   logic [6:0]        glyphSeg;
   logic [6:0]        litSeg;
   logic              litDp;
   logic [DIGITS-1:0] anHot;
   logic [6:0]        physSeg;
   logic              physDp;
   logic [DIGITS-1:0] physAn;

   // Scan prescaler: one tick per CLK_DIV clocks, on the last count of the slot.
   assign tick = (prescaler == PRE_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   always_comb begin
      nextIdx = scanIdx;
      if (tick) begin
         nextIdx = (scanIdx == IDX_LAST) ? '0 : scanIdx + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scanIdx <= '0;
      end else begin
         scanIdx <= nextIdx;
      end
   end

   assign digit_idx = scanIdx;

   // Shadow register: holds the displayed value between loads.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DIGITS; k++) begin
            shadowCode[k] <= CODE_BLANK;
         end
         shadowDp <= '0;
      end else if (load) begin
         for (int k = 0; k < DIGITS; k++) begin
            shadowCode[k] <= num[4*k +: 4];
         end
         shadowDp <= dp_in;
      end
   end

   // Leading-zero mask: walk from the top digit down while every code seen is 0.
   // Digit 0 is excluded so a zero value still shows a single "0".
   always_comb begin
      upperZero = 1'b1;
      lzMask    = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         upperZero = upperZero && (shadowCode[k] == 4'h0);
         lzMask[k] = upperZero && (LZ_BLANK != 0);
      end
   end

   seg7_glyph uGlyph (
      .code     (shadowCode[nextIdx]),
      .hexMode  (HEX_MODE != 0),
      .segments (glyphSeg)
   );

   // Outputs are built from the next index so an anode switch and its glyph
   // land on the same edge as the tick; the shadow used is the pre-load value.
   always_comb begin
      litSeg = lzMask[nextIdx] ? SEG_BLANK : glyphSeg;
      litDp  = shadowDp[nextIdx];
      anHot  = '0;
      anHot[nextIdx] = 1'b1;
      physSeg = (SEG_ACTIVE_LOW != 0) ? ~litSeg : litSeg;
      physDp  = (SEG_ACTIVE_LOW != 0) ? ~litDp  : litDp;
      physAn  = (AN_ACTIVE_LOW  != 0) ? ~anHot  : anHot;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg <= SEG_OFF;
         dp  <= DP_OFF;
         an  <= AN_OFF;
      end else if (!enable) begin
         seg <= SEG_OFF;
         dp  <= DP_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= physSeg;
         dp  <= physDp;
         an  <= physAn;
      end
   end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: 4 digits, CLK_DIV=4, active-low pins,
// leading-zero blanking on; a second instance runs with hex glyphs enabled.
module tb_seg_display_mux;

   logic        clock;
   logic        reset;
   logic [15:0] num;
   logic [3:0]  dpIn;
   logic        load;
   logic        enable;
   logic [6:0]  seg,      segHex;
   logic        dp,       dpHex;
   logic [3:0]  an,       anHex;
   logic [1:0]  digitIdx, digitIdxHex;

   int nCompared;
   int nMismatched;

   seg_display_mux #(
      .DIGITS(4), .CLK_DIV(4), .HEX_MODE(0), .LZ_BLANK(1),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut (
      .clock(clock), .reset(reset), .num(num), .dp_in(dpIn), .load(load),
      .enable(enable), .seg(seg), .dp(dp), .an(an), .digit_idx(digitIdx)
   );

   seg_display_mux #(
      .DIGITS(4), .CLK_DIV(4), .HEX_MODE(1), .LZ_BLANK(1),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dutHex (
      .clock(clock), .reset(reset), .num(num), .dp_in(dpIn), .load(load),
      .enable(enable), .seg(segHex), .dp(dpHex), .an(anHex), .digit_idx(digitIdxHex)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Capture a value; returns once the new shadow is visible on the pins.
   task automatic loadValue(input logic [15:0] value, input logic [3:0] dots);
      num  = value;
      dpIn = dots;
      load = 1'b1;
      @(posedge clock); #1;
      load = 1'b0;
      @(posedge clock); #1;
   endtask

   // Wait (bounded) for digit_idx to transition into target; returns 1 #1 after that edge.
   task automatic waitForIdx(input int target, output bit ok);
      int prev;
      ok   = 1'b0;
      prev = int'(digitIdx);
      for (int c = 0; c < 64; c++) begin
         @(posedge clock); #1;
         if (int'(digitIdx) == target && prev != target) begin
            ok = 1'b1;
            break;
         end
         prev = int'(digitIdx);
      end
   endtask

   task automatic test_reset();
      int firstTick;
      reset = 1'b1;
      #1;
      nCompared++; if (an !== 4'b1111) begin nMismatched++; $display("FAIL reset_an: got %b, required 1111", an); end
      nCompared++; if (seg !== 7'b1111111) begin nMismatched++; $display("FAIL reset_seg: got %b, required 1111111", seg); end
      nCompared++; if (dp !== 1'b1) begin nMismatched++; $display("FAIL reset_dp: got %b, required 1", dp); end
      nCompared++; if (digitIdx !== 2'd0) begin nMismatched++; $display("FAIL reset_idx: got %0d, required 0", digitIdx); end
      @(posedge clock); @(posedge clock); #3;
      reset = 1'b0;
      firstTick = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock); #1;
         if (digitIdx !== 2'd0) begin firstTick = c; break; end
      end
      nCompared++; if (firstTick != 4) begin nMismatched++; $display("FAIL first_tick: got edge %0d, required edge 4", firstTick); end

      // Reset in the middle of a slot: pins blank immediately, fresh full slot afterwards.
      repeat (6) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      nCompared++; if (an !== 4'b1111) begin nMismatched++; $display("FAIL midreset_an: got %b, required 1111", an); end
      nCompared++; if (seg !== 7'b1111111) begin nMismatched++; $display("FAIL midreset_seg: got %b, required 1111111", seg); end
      nCompared++; if (digitIdx !== 2'd0) begin nMismatched++; $display("FAIL midreset_idx: got %0d, required 0", digitIdx); end
      #3 reset = 1'b0;
      firstTick = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock); #1;
         if (c == 1) begin
            nCompared++; if (an !== 4'b1110) begin nMismatched++; $display("FAIL midreset_an0: got %b, required 1110", an); end
         end
         if (digitIdx !== 2'd0) begin firstTick = c; break; end
      end
      nCompared++; if (firstTick != 4) begin nMismatched++; $display("FAIL midreset_tick: got edge %0d, required edge 4", firstTick); end
   endtask

   task automatic test_scan_order();
      logic [6:0] expSeg [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
      logic [3:0] expAn  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      int idx, prevIdx, runLen, changes;
      bit seenChange;
      loadValue(16'h1234, 4'b0000);
      prevIdx = int'(digitIdx);
      runLen = 0; changes = 0; seenChange = 1'b0;
      for (int c = 0; c < 40; c++) begin
         idx = int'(digitIdx);
         if (idx != prevIdx) begin
            changes++;
            nCompared++; if (idx != (prevIdx + 1) % 4) begin nMismatched++; $display("FAIL scan_next: got %0d after %0d, required %0d", idx, prevIdx, (prevIdx + 1) % 4); end
            if (seenChange) begin
               nCompared++; if (runLen != 4) begin nMismatched++; $display("FAIL scan_slot: got %0d cycles, required 4", runLen); end
            end
            seenChange = 1'b1;
            runLen = 0;
         end
         runLen++;
         prevIdx = idx;
         nCompared++; if (an !== expAn[idx]) begin nMismatched++; $display("FAIL scan_an: digit %0d got %b, required %b", idx, an, expAn[idx]); end
         nCompared++; if (seg !== expSeg[idx]) begin nMismatched++; $display("FAIL scan_seg: digit %0d got %b, required %b", idx, seg, expSeg[idx]); end
         nCompared++; if (dp !== 1'b1) begin nMismatched++; $display("FAIL scan_dp: digit %0d got %b, required 1", idx, dp); end
         @(posedge clock); #1;
      end
      nCompared++; if (changes < 9) begin nMismatched++; $display("FAIL scan_changes: got %0d digit changes, required at least 9", changes); end
   endtask

   task automatic test_lz_blank();
      logic [6:0] exp70 [4] = '{7'b0000001, 7'b0001111, 7'b1111111, 7'b1111111};
      logic [6:0] exp00 [4] = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
      int idx;
      loadValue(16'h0070, 4'b0000);
      for (int c = 0; c < 16; c++) begin
         idx = int'(digitIdx);
         nCompared++; if (seg !== exp70[idx]) begin nMismatched++; $display("FAIL lz_0070: digit %0d got %b, required %b", idx, seg, exp70[idx]); end
         @(posedge clock); #1;
      end
      loadValue(16'h0000, 4'b0000);
      for (int c = 0; c < 16; c++) begin
         idx = int'(digitIdx);
         nCompared++; if (seg !== exp00[idx]) begin nMismatched++; $display("FAIL lz_0000: digit %0d got %b, required %b", idx, seg, exp00[idx]); end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_modes();
      // value 1CA5: digit0=5, digit1=A, digit2=C, digit3=1; dp on digit 2 only
      logic [6:0] expDec [4] = '{7'b0100100, 7'b1111110, 7'b1111111, 7'b1001111};
      logic [6:0] expHex [4] = '{7'b0100100, 7'b0001000, 7'b0110001, 7'b1001111};
      logic [3:0] expAn  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      int idx, idxH;
      loadValue(16'h1CA5, 4'b0100);
      for (int c = 0; c < 16; c++) begin
         idx  = int'(digitIdx);
         idxH = int'(digitIdxHex);
         nCompared++; if (seg !== expDec[idx]) begin nMismatched++; $display("FAIL mode_dec_seg: digit %0d got %b, required %b", idx, seg, expDec[idx]); end
         nCompared++; if (segHex !== expHex[idxH]) begin nMismatched++; $display("FAIL mode_hex_seg: digit %0d got %b, required %b", idxH, segHex, expHex[idxH]); end
         nCompared++; if (anHex !== expAn[idxH]) begin nMismatched++; $display("FAIL mode_hex_an: digit %0d got %b, required %b", idxH, anHex, expAn[idxH]); end
         nCompared++; if (dp !== (idx == 2 ? 1'b0 : 1'b1)) begin nMismatched++; $display("FAIL mode_dp: digit %0d got %b, required %b", idx, dp, (idx == 2 ? 1'b0 : 1'b1)); end
         nCompared++; if (dpHex !== (idxH == 2 ? 1'b0 : 1'b1)) begin nMismatched++; $display("FAIL mode_dp_hex: digit %0d got %b, required %b", idxH, dpHex, (idxH == 2 ? 1'b0 : 1'b1)); end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_load_timing();
      bit ok;
      loadValue(16'h1235, 4'b0000);
      waitForIdx(3, ok);
      nCompared++; if (!ok) begin nMismatched++; $display("FAIL load_wait: got timeout, required digit 3"); end
      // Three more edges bring the prescaler to its last count; the next edge is the tick.
      repeat (3) @(posedge clock);
      #1;
      nCompared++; if (an !== 4'b0111) begin nMismatched++; $display("FAIL load_pre_an: got %b, required 0111", an); end
      nCompared++; if (seg !== 7'b1001111) begin nMismatched++; $display("FAIL load_pre_seg: got %b, required 1001111", seg); end
      num  = 16'h1238;
      load = 1'b1;
      @(posedge clock); #1;
      load = 1'b0;
      nCompared++; if (digitIdx !== 2'd0) begin nMismatched++; $display("FAIL load_tick_idx: got %0d, required 0", digitIdx); end
      nCompared++; if (an !== 4'b1110) begin nMismatched++; $display("FAIL load_tick_an: got %b, required 1110", an); end
      nCompared++; if (seg !== 7'b0100100) begin nMismatched++; $display("FAIL load_tick_seg: got %b, required 0100100 (old 5)", seg); end
      @(posedge clock); #1;
      nCompared++; if (an !== 4'b1110) begin nMismatched++; $display("FAIL load_next_an: got %b, required 1110", an); end
      nCompared++; if (seg !== 7'b0000000) begin nMismatched++; $display("FAIL load_next_seg: got %b, required 0000000 (8)", seg); end
   endtask

   task automatic test_enable();
      bit ok;
      logic [1:0] expIdx [3] = '{2'd1, 2'd1, 2'd2};
      waitForIdx(1, ok);
      nCompared++; if (!ok) begin nMismatched++; $display("FAIL en_wait: got timeout, required digit 1"); end
      @(posedge clock); #1;
      enable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #1;
         nCompared++; if (an !== 4'b1111) begin nMismatched++; $display("FAIL en_off_an: cycle %0d got %b, required 1111", c, an); end
         nCompared++; if (seg !== 7'b1111111) begin nMismatched++; $display("FAIL en_off_seg: cycle %0d got %b, required 1111111", c, seg); end
         nCompared++; if (dp !== 1'b1) begin nMismatched++; $display("FAIL en_off_dp: cycle %0d got %b, required 1", c, dp); end
         nCompared++; if (digitIdx !== expIdx[c]) begin nMismatched++; $display("FAIL en_off_idx: cycle %0d got %0d, required %0d", c, digitIdx, expIdx[c]); end
      end
      enable = 1'b1;
      @(posedge clock); #1;
      nCompared++; if (digitIdx !== 2'd2) begin nMismatched++; $display("FAIL en_on_idx: got %0d, required 2", digitIdx); end
      nCompared++; if (an !== 4'b1011) begin nMismatched++; $display("FAIL en_on_an: got %b, required 1011", an); end
      nCompared++; if (seg !== 7'b0010010) begin nMismatched++; $display("FAIL en_on_seg: got %b, required 0010010", seg); end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      reset  = 1'b0;
      num    = 16'h0000;
      dpIn   = 4'b0000;
      load   = 1'b0;
      enable = 1'b1;
      #2;
      test_reset();
      test_scan_order();
      test_lz_blank();
      test_modes();
      test_load_timing();
      test_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
